rr_mux_arb: RTL and testbench
=============================

Name: rr_mux_arb

Overview:
- Parametrised M-input, N-bit registered multiplexer; successor to the combinational 4:1 mux tree.
- Adds valid/ready handshakes on every input and on the output.
- Built-in arbiter with three modes: round-robin, fixed priority, forced select.
- One output register stage; sits between multiple producers (ALU/memory result paths) and a single consumer.

Parameters:
- N, 32, data width per channel.
- M, 4, number of input channels (2..2^SEL_W).
- SEL_W, 2, width of channel index fields.

Ports:
- clk  input  1  clock, rising edge.
- rstb  input  1  asynchronous, active-low reset.
- mode  input  2  0=round-robin, 1=fixed priority (lowest index wins), 2=forced select, 3=reserved (no grants).
- sel  input  SEL_W  channel index used in forced mode.
- in_data  input  M*N  channel i occupies bits [i*N+N-1 : i*N].
- in_valid  input  M  per-channel valid.
- in_ready  output  M  per-channel ready; combinational.
- out_data  output  N  registered data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rstb low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0, rr pointer=0.
  - in_ready=0 while rstb is low.
- load_ok = !out_valid | out_ready. The output register accepts a new word whenever it is empty or is being drained in the same cycle.
- Grant is a combinational, one-hot (or zero) vector computed from in_valid, mode, sel and the rr pointer.
  - Round-robin: first valid channel searching ptr, ptr+1, ..., M-1, 0, ..., ptr-1.
  - Fixed priority: lowest-index valid channel.
  - Forced: channel sel if sel<M and in_valid[sel]; otherwise no grant.
  - Mode 3: no grant.
- in_ready[i] = grant[i] & load_ok & rstb.
- Exactly one in_ready is high at most; in_ready never depends on in_data.
- Transfer occurs on channel g when in_valid[g] & in_ready[g]. At the clock edge:
  - out_data<=channel g data, out_sel<=g, out_valid<=1.
  - Latency is one cycle from accepted input to out_valid.
- rr pointer:
  - Updates only on a transfer in round-robin mode: ptr<=g+1, wrapping M-1 -> 0.
  - Unchanged in fixed and forced modes.
- Drain without load (out_valid & out_ready & no transfer): out_valid<=0. out_data and out_sel hold their last values.
- Stall (out_valid & !out_ready): out_data, out_sel and out_valid hold; all in_ready=0.
- Simultaneous drain and load: new word replaces old in the same edge; out_valid stays 1. Full throughput is one word per cycle.
- Mode or sel changes take effect on the next grant computation. A word already in the output register is unaffected.
- Producers must hold in_valid and in_data until accepted. The block does not latch unaccepted requests.
- Reset asserted mid-transfer discards the registered word; no partial state survives.
- Width rules: no arithmetic on data. Pointer increment is done in SEL_W bits with explicit wrap at M-1, so non-power-of-two M is supported.

Test Plan:
- Reset release, M=4, all in_valid=0 -> out_valid=0, out_data=0, in_ready=0000 for 5 cycles.
- Round-robin, all 4 valid with data 0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0; out_valid continuously 1 from cycle 1; one word per cycle.
- Fixed priority, in_valid=1010, out_ready=1 -> channel 1 granted every cycle; channel 3 starves; in_ready=0010.
- Forced mode sel=2, in_valid=1111:
  - out_ready held 0 for 3 cycles -> out_data=channel 2 word held, in_ready=0000.
  - out_ready then 1 -> next word from channel 2 loads on the same edge.
- Forced mode sel=2, in_valid=1011 -> no grant, out_valid drops to 0 after the drain; switching to mode 0 with ptr=3 -> channel 3 granted next.
- M=3 build: round-robin wrap ptr 2->0; rstb pulsed low mid-stream -> out_valid=0 and ptr=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rr_mux_arb.sv
// M-input registered multiplexer with valid/ready handshakes on every port and
// a built-in arbiter (round-robin, fixed priority, forced select).
module rr_mux_arb #(
    parameter int unsigned N     = 32,
    parameter int unsigned M     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [1:0]           mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [M*N-1:0]       in_data,
    input  logic [M-1:0]         in_valid,
    output logic [M-1:0]         in_ready,
    output logic [N-1:0]         out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [1:0]       MODE_RR    = 2'd0;
    localparam logic [1:0]       MODE_FIX   = 2'd1;
    localparam logic [1:0]       MODE_FORCE = 2'd2;
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(M - 1);

    logic [SEL_W-1:0] ptr;
    logic [M-1:0]     grant;
    logic [SEL_W-1:0] gidx;
    logic             gnt_any;
    logic             load_ok;
    logic             xfer;
    logic [N-1:0]     sel_data;

    // Grant selection; round-robin scans ptr..M-1 first, then 0..ptr-1.
    always_comb begin
        gidx    = '0;
        gnt_any = 1'b0;
        case (mode)
            MODE_RR: begin
                for (int unsigned j = 0; j < M; j++) begin
                    if (!gnt_any && j >= 32'(ptr) && in_valid[j]) begin
                        gnt_any = 1'b1;
                        gidx    = SEL_W'(j);
                    end
                end
                for (int unsigned j = 0; j < M; j++) begin
                    if (!gnt_any && j < 32'(ptr) && in_valid[j]) begin
                        gnt_any = 1'b1;
                        gidx    = SEL_W'(j);
                    end
                end
            end
            MODE_FIX: begin
                for (int unsigned j = 0; j < M; j++) begin
                    if (!gnt_any && in_valid[j]) begin
                        gnt_any = 1'b1;
                        gidx    = SEL_W'(j);
                    end
                end
            end
            MODE_FORCE: begin
                for (int unsigned j = 0; j < M; j++) begin
                    if (!gnt_any && SEL_W'(j) == sel && in_valid[j]) begin
                        gnt_any = 1'b1;
                        gidx    = SEL_W'(j);
                    end
                end
            end
            default: ;
        endcase
    end

    // One-hot grant vector and the matching data word.
    always_comb begin
        grant    = '0;
        sel_data = '0;
        for (int unsigned j = 0; j < M; j++) begin
            if (gnt_any && gidx == SEL_W'(j)) begin
                grant[j] = 1'b1;
                sel_data = in_data[j*N +: N];
            end
        end
    end

    assign load_ok  = !out_valid || out_ready;
    assign xfer     = gnt_any && load_ok;
    assign in_ready = grant & {M{load_ok && rstb}};

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gidx;
            if (mode == MODE_RR) begin
                ptr <= (gidx == LAST_IDX) ? '0 : gidx + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb (M=4 and M=3 builds) with a per-cycle
// behavioural reference model and hand-computed literal checkpoints.
module tb_rr_mux_arb;

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   mode4 = 2'd0, sel4 = 2'd0;
    logic [127:0] data4 = '0;
    logic [3:0]   valid4 = '0, rdy4;
    logic [31:0]  od4;
    logic [1:0]   os4;
    logic         ov4, ordy4 = 1'b0;

    logic [1:0]   mode3 = 2'd0, sel3 = 2'd0;
    logic [95:0]  data3 = '0;
    logic [2:0]   valid3 = '0, rdy3;
    logic [31:0]  od3;
    logic [1:0]   os3;
    logic         ov3, ordy3 = 1'b0;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    rr_mux_arb #(.N(32), .M(4), .SEL_W(2)) dut4 (
        .clk(clk), .rstb(rstb), .mode(mode4), .sel(sel4), .in_data(data4),
        .in_valid(valid4), .in_ready(rdy4), .out_data(od4), .out_sel(os4),
        .out_valid(ov4), .out_ready(ordy4));

    rr_mux_arb #(.N(32), .M(3), .SEL_W(2)) dut3 (
        .clk(clk), .rstb(rstb), .mode(mode3), .sel(sel3), .in_data(data3),
        .in_valid(valid3), .in_ready(rdy3), .out_data(od3), .out_sel(os3),
        .out_valid(ov3), .out_ready(ordy3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Winning channel from the arbitration rules, -1 when nothing is granted.
    function automatic int mgrant(input int m, input logic [1:0] md, input logic [1:0] s,
                                  input logic [3:0] v, input int p);
        case (md)
            2'd0: for (int k = 0; k < m; k++) if (v[(p + k) % m]) return (p + k) % m;
            2'd1: for (int k = 0; k < m; k++) if (v[k]) return k;
            2'd2: if (int'(s) < m && v[s]) return int'(s);
            default: ;
        endcase
        return -1;
    endfunction

    // Reference state: output register contents and pointer per build.
    logic        mv4, mv3;
    logic [31:0] md4, md3;
    int          ms4, ms3, mp4, mp3;
    int          g4, g3;
    logic [3:0]  er4;
    logic [2:0]  er3;

    always_comb begin
        g4  = mgrant(4, mode4, sel4, valid4, mp4);
        g3  = mgrant(3, mode3, sel3, 4'(valid3), mp3);
        er4 = (rstb && g4 >= 0 && (!mv4 || ordy4)) ? 4'(1 << g4) : 4'd0;
        er3 = (rstb && g3 >= 0 && (!mv3 || ordy3)) ? 3'(1 << g3) : 3'd0;
    end

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mv4 <= 1'b0; md4 <= '0; ms4 <= 0; mp4 <= 0;
        end else if (g4 >= 0 && (!mv4 || ordy4)) begin
            mv4 <= 1'b1; md4 <= data4[g4*32 +: 32]; ms4 <= g4;
            if (mode4 == 2'd0) mp4 <= (g4 + 1) % 4;
        end else if (ordy4) begin
            mv4 <= 1'b0;
        end
    end

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mv3 <= 1'b0; md3 <= '0; ms3 <= 0; mp3 <= 0;
        end else if (g3 >= 0 && (!mv3 || ordy3)) begin
            mv3 <= 1'b1; md3 <= data3[g3*32 +: 32]; ms3 <= g3;
            if (mode3 == 2'd0) mp3 <= (g3 + 1) % 3;
        end else if (ordy3) begin
            mv3 <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("m4_in_ready", 32'(rdy4), 32'(er4));
            chk("m4_out_valid", 32'(ov4), 32'(mv4));
            chk("m4_out_data", od4, md4);
            chk("m4_out_sel", 32'(os4), 32'(ms4));
            chk("m3_in_ready", 32'(rdy3), 32'(er3));
            chk("m3_out_valid", 32'(ov3), 32'(mv3));
            chk("m3_out_data", od3, md3);
            chk("m3_out_sel", 32'(os3), 32'(ms3));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #1 rstb = 1'b0;
        cyc(2);
        run = 1'b1;
        cyc(1);
        rstb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("rst_out_valid", 32'(ov4), 32'h0);
            chk("rst_out_data", od4, 32'h0);
            chk("rst_in_ready", 32'(rdy4), 32'h0);
        end

        // Round-robin, all channels valid.
        mode4 = 2'd0; valid4 = 4'hf; ordy4 = 1'b1;
        data4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        #1 chk("rr_first_ready", 32'(rdy4), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("rr_sel_seq", 32'(os4), 32'(i % 4));
            chk("rr_data_seq", od4, 32'hA0 + 32'(i % 4));
            chk("rr_valid", 32'(ov4), 32'h1);
        end

        // Fixed priority: channel 1 always beats channel 3.
        mode4 = 2'd1; valid4 = 4'b1010;
        #1 chk("fix_ready", 32'(rdy4), 32'h2);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("fix_sel", 32'(os4), 32'h1);
            chk("fix_data", od4, 32'hA1);
        end

        // Forced channel 2, then stall with a new pending word on channel 2.
        mode4 = 2'd2; sel4 = 2'd2; valid4 = 4'hf;
        cyc(1);
        chk("force_sel", 32'(os4), 32'h2);
        chk("force_data", od4, 32'hA2);
        data4[95:64] = 32'hC2; ordy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", 32'(rdy4), 32'h0);
            cyc(1);
            chk("stall_data", od4, 32'hA2);
            chk("stall_valid", 32'(ov4), 32'h1);
        end
        ordy4 = 1'b1;
        #1 chk("unstall_ready", 32'(rdy4), 32'h4);
        cyc(1);
        chk("unstall_data", od4, 32'hC2);
        chk("unstall_valid", 32'(ov4), 32'h1);

        // Round-robin from ptr=1 with only channel 2 valid leaves ptr=3.
        mode4 = 2'd0; valid4 = 4'b0100;
        #1 chk("rr_only2_ready", 32'(rdy4), 32'h4);
        cyc(1);
        chk("rr_only2_sel", 32'(os4), 32'h2);

        // Forced channel 2 not valid: no grant, register drains.
        mode4 = 2'd2; valid4 = 4'b1011;
        #1 chk("force_nogrant_ready", 32'(rdy4), 32'h0);
        cyc(1);
        chk("drain_valid", 32'(ov4), 32'h0);
        chk("drain_data_hold", od4, 32'hC2);
        chk("drain_sel_hold", 32'(os4), 32'h2);

        mode4 = 2'd3; valid4 = 4'hf;
        #1 chk("mode3_ready", 32'(rdy4), 32'h0);
        cyc(1);
        chk("mode3_valid", 32'(ov4), 32'h0);

        mode4 = 2'd0; valid4 = 4'b1011;
        #1 chk("rr_ptr3_ready", 32'(rdy4), 32'h8);
        cyc(1);
        chk("rr_ptr3_sel", 32'(os4), 32'h3);
        chk("rr_ptr3_data", od4, 32'hA3);
        valid4 = 4'h0;
        cyc(1);
        chk("idle_valid", 32'(ov4), 32'h0);

        // M=3 round-robin wrap, then asynchronous reset mid-stream.
        mode3 = 2'd0; valid3 = 3'b111; ordy3 = 1'b1;
        data3 = {32'hB2, 32'hB1, 32'hB0};
        #1 chk("m3_first_ready", 32'(rdy3), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("m3_sel_seq", 32'(os3), 32'(i % 3));
            chk("m3_data_seq", od3, 32'hB0 + 32'(i % 3));
        end
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ov3), 32'h0);
        chk("async_rst_data", od3, 32'h0);
        chk("async_rst_sel", 32'(os3), 32'h0);
        chk("async_rst_ready", 32'(rdy3), 32'h0);
        cyc(1);
        rstb = 1'b1;
        #1 chk("m3_ptr_reset_ready", 32'(rdy3), 32'h1);
        cyc(1);
        chk("m3_after_rst_sel", 32'(os3), 32'h0);
        chk("m3_after_rst_data", od3, 32'hB0);
        valid3 = 3'b000;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
